// File: rtl/dac_segment_encoder.sv
// Buffers sample codes and emits one per update tick as 7 binary LSBs plus a 17-element thermometer (DAC_DEM_EN enables DWA rotation).
// Latency: first tick edge after the push edge; s_ready drops while the FIFO is full; an empty FIFO on a tick holds the outputs and counts an underflow.

module dac_seg_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_vld,
  input  logic [W-1:0]               i_wr_dat,
  output logic                       o_wr_rdy,
  input  logic                       i_rd_en,
  output logic [W-1:0]               o_rd_dat,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;

  assign o_wr_rdy = (r_count != (AW+1)'(DEPTH));
  assign w_push   = i_wr_vld && o_wr_rdy;
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_count  = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, i_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module dac_segment_encoder #(
  parameter int CODE_W     = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int UPDATE_DIV = 4,
  parameter int PRIME_LVL  = 2
) (
  input  logic              clkin,
  input  logic              pdb,
  input  logic              enable,
  input  logic              s_valid,
  input  logic [CODE_W-1:0] s_code,
  output logic              s_ready,
  output logic [6:0]        datainbin,
  output logic [6:0]        datainbinb,
  output logic [16:0]       dataintherm,
  output logic [16:0]       datainthermb,
  output logic              clip,
  output logic [15:0]       underflow_cnt
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [AW:0]         PRIME_CNT  = (AW+1)'(PRIME_LVL);
  localparam logic [CNT_W-1:0]    TICK_LAST  = CNT_W'(UPDATE_DIV - 1);
  localparam logic [CODE_W-1:0]   FULL_SCALE = CODE_W'(2303);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic [6:0]        r_bin, r_binb;
  logic [16:0]       r_therm, r_thermb;
  logic              r_clip;
  logic [15:0]       r_uf_cnt;
  logic [CODE_W-1:0] w_head;
  logic [AW:0]       w_count;
  logic              w_tick, w_empty, w_pop, w_over;
  logic [CODE_W-1:0] w_c;
  logic [4:0]        w_n;
  logic [16:0]       w_base, w_therm;

  dac_seg_fifo #(.W(CODE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk    (clkin),
    .i_rst_n  (pdb),
    .i_wr_vld (s_valid),
    .i_wr_dat (s_code),
    .o_wr_rdy (s_ready),
    .i_rd_en  (w_pop),
    .o_rd_dat (w_head),
    .o_count  (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (enable && (w_count >= PRIME_CNT)) w_state_nxt = ST_RUN;
      ST_RUN:  if (!enable) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A tick is suppressed on the cycle RUN is being left, so stopping never pops.
  assign w_tick  = (r_state == ST_RUN) && enable && (r_tick_cnt == TICK_LAST);
  assign w_empty = (w_count == '0);
  assign w_pop   = w_tick && !w_empty;

  assign w_over = (w_head > FULL_SCALE);
  assign w_c    = w_over ? FULL_SCALE : w_head;
  assign w_n    = 5'(w_c >> 7);
  assign w_base = 17'((18'd1 << w_n) - 18'd1);

`ifdef DAC_DEM_EN
  logic [4:0]  r_dem_ptr;
  logic [33:0] w_dbl;
  logic [5:0]  w_ptr_sum;

  // Rotate the unary pattern left by the pointer, wrapping modulo 17 elements.
  assign w_dbl     = {17'd0, w_base} << r_dem_ptr;
  assign w_therm   = w_dbl[16:0] | w_dbl[33:17];
  assign w_ptr_sum = {1'b0, r_dem_ptr} + {1'b0, w_n};

  always_ff @(posedge clkin) begin
    if (!pdb)       r_dem_ptr <= '0;
    else if (w_pop) r_dem_ptr <= (w_ptr_sum >= 6'd17) ? 5'(w_ptr_sum - 6'd17) : w_ptr_sum[4:0];
  end
`else
  assign w_therm = w_base;
`endif

  always_ff @(posedge clkin) begin
    if (!pdb) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bin      <= '0;
      r_binb     <= '1;
      r_therm    <= '0;
      r_thermb   <= '1;
      r_clip     <= 1'b0;
      r_uf_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_RUN) && enable) r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      else                               r_tick_cnt <= '0;
      r_clip <= w_pop && w_over;
      if (w_pop) begin
        r_bin    <= w_c[6:0];
        r_binb   <= ~w_c[6:0];
        r_therm  <= w_therm;
        r_thermb <= ~w_therm;
      end
      if (w_tick && w_empty && (r_uf_cnt != 16'hFFFF)) r_uf_cnt <= r_uf_cnt + 16'd1;
    end
  end

  assign datainbin     = r_bin;
  assign datainbinb    = r_binb;
  assign dataintherm   = r_therm;
  assign datainthermb  = r_thermb;
  assign clip          = r_clip;
  assign underflow_cnt = r_uf_cnt;
endmodule

// File: tb/tb_dac_segment_encoder.sv
// Scoreboard bench for dac_segment_encoder: expectations are queued at push time and compared at each update tick.
`timescale 1ns/1ps
module tb_dac_segment_encoder;
  typedef struct packed {
    logic [6:0]  bin;
    logic [16:0] therm;
    logic        clip;
  } exp_t;

  logic        clkin = 1'b0;
  logic        pdb, enable, s_valid, s_ready, clip;
  logic [11:0] s_code;
  logic [6:0]  datainbin, datainbinb;
  logic [16:0] dataintherm, datainthermb;
  logic [15:0] underflow_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_p     = 0;
  exp_t q_exp[$];
  exp_t cur;

  always #5 clkin = ~clkin;

  dac_segment_encoder dut (
    .clkin(clkin), .pdb(pdb), .enable(enable), .s_valid(s_valid), .s_code(s_code),
    .s_ready(s_ready), .datainbin(datainbin), .datainbinb(datainbinb),
    .dataintherm(dataintherm), .datainthermb(datainthermb), .clip(clip),
    .underflow_cnt(underflow_cnt)
  );

  // Reference encoding: clamp, split, and place n unary elements starting at the DWA pointer.
  function automatic exp_t model_encode(input int code);
    exp_t e;
    int   c, n;
    c       = (code > 2303) ? 2303 : code;
    n       = c / 128;
    e.bin   = 7'(c % 128);
    e.clip  = (code > 2303);
    e.therm = '0;
`ifdef DAC_DEM_EN
    for (int i = 0; i < n; i++) e.therm[(m_p + i) % 17] = 1'b1;
    m_p = (m_p + n) % 17;
`else
    for (int i = 0; i < n; i++) e.therm[i] = 1'b1;
`endif
    return e;
  endfunction

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic push_one(input int code);
    s_valid = 1'b1;
    s_code  = 12'(code);
    if (s_ready) q_exp.push_back(model_encode(code));
    step();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    pdb = 1'b0; enable = 1'b0; s_valid = 1'b0; s_code = '0;
    step(); step();
    n_tests++;
    if ({datainbin, datainbinb, dataintherm, datainthermb} !== {7'h00, 7'h7F, 17'h00000, 17'h1FFFF}) begin
      n_fail++;
      $display("FAIL reset_outputs: got bin=%h binb=%h therm=%h thermb=%h, want 00 7f 00000 1ffff",
               datainbin, datainbinb, dataintherm, datainthermb);
    end
    n_tests++;
    if ({s_ready, clip, underflow_cnt} !== {1'b1, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_status: got s_ready=%b clip=%b uf=%0d, want 1 0 0", s_ready, clip, underflow_cnt);
    end
    pdb = 1'b1;
    cur = '0;
    m_p = 0;
    step();
  endtask

  task automatic test_encode();
    exp_t e;
    enable = 1'b0; step();
    push_one(0); push_one(127); push_one(128); push_one(2303);
    enable = 1'b1; step();
    for (int k = 0; k < 4; k++) begin
      for (int j = 1; j <= 4; j++) begin
        step();
        n_tests++;
        if (j < 4) begin
          if ({datainbin, dataintherm, clip} !== {cur.bin, cur.therm, 1'b0}) begin
            n_fail++;
            $display("FAIL encode_hold[%0d.%0d]: got %h/%h clip=%b, want %h/%h clip=0",
                     k, j, datainbin, dataintherm, clip, cur.bin, cur.therm);
          end
        end else if (q_exp.size() == 0) begin
          n_fail++;
          $display("FAIL encode_queue[%0d]: scoreboard empty, want an entry", k);
        end else begin
          e = q_exp.pop_front();
          if ({datainbin, dataintherm, clip, datainbinb, datainthermb} !== {e.bin, e.therm, e.clip, ~e.bin, ~e.therm}) begin
            n_fail++;
            $display("FAIL encode_emit[%0d]: got %h/%h clip=%b comp=%h/%h, want %h/%h clip=%b",
                     k, datainbin, dataintherm, clip, datainbinb, datainthermb, e.bin, e.therm, e.clip);
          end
          cur = e;
        end
      end
    end
    enable = 1'b0; step();
  endtask

  task automatic test_clamp();
    exp_t e;
    push_one(4095); push_one(2303);
    enable = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      for (int j = 1; j <= 4; j++) begin
        step();
        n_tests++;
        if (j < 4) begin
          if ({datainbin, dataintherm, clip} !== {cur.bin, cur.therm, 1'b0}) begin
            n_fail++;
            $display("FAIL clamp_hold[%0d.%0d]: got %h/%h clip=%b, want %h/%h clip=0",
                     k, j, datainbin, dataintherm, clip, cur.bin, cur.therm);
          end
        end else begin
          e = q_exp.pop_front();
          if ({datainbin, dataintherm, clip, datainbinb, datainthermb} !== {e.bin, e.therm, e.clip, ~e.bin, ~e.therm}) begin
            n_fail++;
            $display("FAIL clamp_emit[%0d]: got %h/%h clip=%b comp=%h/%h, want %h/%h clip=%b",
                     k, datainbin, dataintherm, clip, datainbinb, datainthermb, e.bin, e.therm, e.clip);
          end
          cur = e;
        end
      end
    end
    enable = 1'b0; step();
  endtask

  task automatic test_underflow();
    exp_t e;
    int   uf_exp;
    uf_exp = 0;
    push_one(100); push_one(200);
    enable = 1'b1; step();
    for (int k = 0; k < 5; k++) begin
      for (int j = 1; j <= 4; j++) begin
        step();
        if (j == 4 && k < 2) begin
          e   = q_exp.pop_front();
          cur = e;
        end else if (j == 4) begin
          uf_exp++;
        end
        n_tests++;
        if ({datainbin, dataintherm, underflow_cnt, s_ready} !== {cur.bin, cur.therm, 16'(uf_exp), 1'b1}) begin
          n_fail++;
          $display("FAIL underflow[%0d.%0d]: got %h/%h uf=%0d s_ready=%b, want %h/%h uf=%0d s_ready=1",
                   k, j, datainbin, dataintherm, underflow_cnt, s_ready, cur.bin, cur.therm, uf_exp);
        end
      end
    end
    enable = 1'b0; step();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   codes[9] = '{5, 300, 1000, 3000, 2303, 1280, 129, 4095, 77};
    int   accepted;
    logic acc;
    accepted = 0;
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1;
      s_code  = 12'(codes[i]);
      acc     = s_ready;
      if (acc) begin
        q_exp.push_back(model_encode(codes[i]));
        accepted++;
      end
      step();
      if (i >= 6) begin
        n_tests++;
        if (s_ready !== (i < 7)) begin
          n_fail++;
          $display("FAIL bp_ready[%0d]: got s_ready=%b, want %b", i, s_ready, (i < 7));
        end
      end
    end
    s_valid = 1'b0;
    n_tests++;
    if (accepted != 8) begin
      n_fail++;
      $display("FAIL bp_accepted: got %0d accepts, want 8", accepted);
    end
    enable = 1'b1; step();
    for (int k = 0; k < 8; k++) begin
      repeat (4) step();
      e = q_exp.pop_front();
      n_tests++;
      if ({datainbin, dataintherm, clip, datainbinb, datainthermb} !== {e.bin, e.therm, e.clip, ~e.bin, ~e.therm}) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: got %h/%h clip=%b comp=%h/%h, want %h/%h clip=%b",
                 k, datainbin, dataintherm, clip, datainbinb, datainthermb, e.bin, e.therm, e.clip);
      end
      cur = e;
    end
    enable = 1'b0; step();
  endtask

  task automatic test_reset_midstream();
    push_one(500); push_one(1500); push_one(2200);
    enable = 1'b1; step();
    repeat (6) step();
    pdb = 1'b0;
    step(); step();
    n_tests++;
    if ({datainbin, datainbinb, dataintherm, datainthermb, clip} !== {7'h00, 7'h7F, 17'h00000, 17'h1FFFF, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got bin=%h binb=%h therm=%h thermb=%h clip=%b, want 00 7f 00000 1ffff 0",
               datainbin, datainbinb, dataintherm, datainthermb, clip);
    end
    n_tests++;
    if ({s_ready, underflow_cnt} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL midreset_status: got s_ready=%b uf=%0d, want 1 0", s_ready, underflow_cnt);
    end
    q_exp.delete();
    m_p = 0;
    cur = '0;
    pdb = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      n_tests++;
      if ({datainbin, dataintherm, underflow_cnt} !== {7'h00, 17'h00000, 16'h0000}) begin
        n_fail++;
        $display("FAIL midreset_flushed[%0d]: got %h/%h uf=%0d, want 00/00000 uf=0",
                 j, datainbin, dataintherm, underflow_cnt);
      end
    end
    enable = 1'b0; step();
  endtask

`ifdef DAC_DEM_EN
  task automatic test_dem();
    logic [16:0] want[3] = '{17'h00007, 17'h00038, 17'h1FFDF};
    pdb = 1'b0; step(); pdb = 1'b1; m_p = 0; q_exp.delete(); step();
    push_one(384); push_one(384); push_one(2048);
    q_exp.delete();
    enable = 1'b1; step();
    for (int k = 0; k < 3; k++) begin
      repeat (4) step();
      n_tests++;
      if (dataintherm !== want[k]) begin
        n_fail++;
        $display("FAIL dem_therm[%0d]: got %h, want %h", k, dataintherm, want[k]);
      end
    end
    enable = 1'b0; step();
  endtask
`endif

  initial begin
    test_reset();
    test_encode();
    test_clamp();
    test_underflow();
    test_backpressure();
    test_reset_midstream();
`ifdef DAC_DEM_EN
    test_dem();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
